// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode pipeline buffer.
// Holds {pc, instruction} pairs from fetch in a small circular FIFO and
// presents the head entry to decode through a valid/ready handshake.
// Ready and valid come straight from registered occupancy, so the buffer
// has no combinational path from in_* to out_* or from out_ready to in_ready.
// A synchronous flush empties the buffer for taken branches and jumps.
// Optional build macro: IFID_STATS_EN adds the stall_cycles and flush_count
// statistics outputs.
module if_id_buffer #(
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [XLEN-1:0]  NOP_INSTR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_pc_plus4,
    output logic [XLEN-1:0]  out_instr,
    input  logic             out_ready
`ifdef IFID_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [15:0]      flush_count
`endif
);

    localparam int unsigned     PW   = $clog2(DEPTH);
    localparam int unsigned     CW   = PW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);

    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;

    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    // Pointer and occupancy update; flush overrides any push or pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: cleared on reset, written at the tail on every push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

    // Head presentation: empty buffer shows pc 0 and the NOP instruction.
    always_comb begin
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc    = r_pc_mem[r_rd_ptr];
            out_instr = r_instr_mem[r_rd_ptr];
        end
        out_pc_plus4 = out_pc + XLEN'(4);
    end

`ifdef IFID_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;
    logic        w_stall;

    assign w_stall      = in_valid & ~in_ready;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

    // Saturating statistics counters; only reset clears them, flush does not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end
`endif

endmodule
